// File: rtl/rle_channel_arbiter.sv
// Three-channel (Y/U/V) round-robin arbiter feeding RLE blocks to a single serializer.
// Tracks completed blocks per frame and abandons blocks the serializer never finishes.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no block in flight; grant when enabled, serializer ready and a request is pending
// WAIT_DONE | block handed to serializer; waiting for mux_done or watchdog expiry
module rle_channel_arbiter #(
    parameter int BLOCKS_PER_FRAME = 1200,
    parameter int WATCHDOG_CYCLES  = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic [2:0]    req_valid,
    input  logic [1023:0] req_block0,
    input  logic [1023:0] req_block1,
    input  logic [1023:0] req_block2,
    input  logic [6:0]    req_pairs0,
    input  logic [6:0]    req_pairs1,
    input  logic [6:0]    req_pairs2,
    output logic [2:0]    req_ack,
    output logic [1023:0] mux_block,
    output logic [6:0]    mux_pairs,
    output logic [1:0]    mux_channel,
    output logic          mux_valid,
    input  logic          mux_ready,
    input  logic          mux_done,
    output logic          busy,
    output logic          frame_done,
    output logic          clamp_flag,
    output logic          timeout_err
);
    localparam int BW = $clog2(BLOCKS_PER_FRAME + 1);
    localparam int WW = $clog2(WATCHDOG_CYCLES + 1);
    localparam logic [6:0] MAX_PAIRS = 7'd64;

    typedef enum logic {IDLE, WAIT_DONE} state_t;

    state_t        state;
    logic [1:0]    last_grant;
    logic [BW-1:0] blk_cnt;
    logic [WW-1:0] watchdog;

    logic [1:0]    cand0, cand1, cand2;
    logic [1:0]    sel;
    logic [1023:0] sel_block;
    logic [6:0]    sel_pairs;
    logic          sel_over;
    logic          grant;

    // Scan order starts one past the last granted channel, wrapping 2 -> 0.
    always_comb begin
        cand0 = (last_grant == 2'd2) ? 2'd0 : last_grant + 2'd1;
        cand1 = (cand0 == 2'd2) ? 2'd0 : cand0 + 2'd1;
        cand2 = (cand1 == 2'd2) ? 2'd0 : cand1 + 2'd1;
        sel   = cand2;
        if (req_valid[cand0])
            sel = cand0;
        else if (req_valid[cand1])
            sel = cand1;
    end

    always_comb begin
        sel_block = req_block0;
        sel_pairs = req_pairs0;
        case (sel)
            2'd1: begin
                sel_block = req_block1;
                sel_pairs = req_pairs1;
            end
            2'd2: begin
                sel_block = req_block2;
                sel_pairs = req_pairs2;
            end
            default: ;
        endcase
    end

    assign sel_over = (sel_pairs > MAX_PAIRS);
    assign grant    = (state == IDLE) && enable && mux_ready && (|req_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= 2'd2;
            blk_cnt     <= '0;
            watchdog    <= '0;
            req_ack     <= '0;
            mux_block   <= '0;
            mux_pairs   <= '0;
            mux_channel <= '0;
            mux_valid   <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            clamp_flag  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            mux_valid  <= 1'b0;
            req_ack    <= '0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        mux_block   <= sel_block;
                        mux_pairs   <= sel_over ? MAX_PAIRS : sel_pairs;
                        mux_channel <= sel;
                        mux_valid   <= 1'b1;
                        req_ack     <= 3'b001 << sel;
                        last_grant  <= sel;
                        watchdog    <= WW'(WATCHDOG_CYCLES - 1);
                        busy        <= 1'b1;
                        state       <= WAIT_DONE;
                        if (sel_over)
                            clamp_flag <= 1'b1;
                    end
                end
                WAIT_DONE: begin
                    // A completion on the expiry edge wins over the timeout.
                    if (mux_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (blk_cnt == BW'(BLOCKS_PER_FRAME - 1)) begin
                            blk_cnt    <= '0;
                            frame_done <= 1'b1;
                        end else begin
                            blk_cnt <= blk_cnt + 1'b1;
                        end
                    end else if (watchdog == '0) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        watchdog <= watchdog - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rle_channel_arbiter.sv
// Directed bench for rle_channel_arbiter with small frame and watchdog sizes.
module tb_rle_channel_arbiter;
    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [2:0]    req_valid;
    logic [1023:0] req_block0, req_block1, req_block2;
    logic [6:0]    req_pairs0, req_pairs1, req_pairs2;
    logic [2:0]    req_ack;
    logic [1023:0] mux_block;
    logic [6:0]    mux_pairs;
    logic [1:0]    mux_channel;
    logic          mux_valid;
    logic          mux_ready;
    logic          mux_done;
    logic          busy;
    logic          frame_done;
    logic          clamp_flag;
    logic          timeout_err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_frame = 0;

    rle_channel_arbiter #(.BLOCKS_PER_FRAME(4), .WATCHDOG_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .req_valid(req_valid),
        .req_block0(req_block0), .req_block1(req_block1), .req_block2(req_block2),
        .req_pairs0(req_pairs0), .req_pairs1(req_pairs1), .req_pairs2(req_pairs2),
        .req_ack(req_ack), .mux_block(mux_block), .mux_pairs(mux_pairs),
        .mux_channel(mux_channel), .mux_valid(mux_valid), .mux_ready(mux_ready),
        .mux_done(mux_done), .busy(busy), .frame_done(frame_done),
        .clamp_flag(clamp_flag), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (frame_done) n_frame++;
    endtask

    initial begin
        logic [1023:0] exp_blk [3];
        logic [6:0]    exp_pairs [3];
        int got, last_v, n;

        exp_blk[0] = {64{16'h1A01}};
        exp_blk[1] = {64{16'h2B02}};
        exp_blk[2] = {64{16'h3C03}};
        req_block0 = exp_blk[0];
        req_block1 = exp_blk[1];
        req_block2 = exp_blk[2];
        req_pairs0 = 7'd5;
        req_pairs1 = 7'd5;
        req_pairs2 = 7'd5;
        rst = 1'b1; enable = 1'b0; req_valid = 3'b000; mux_ready = 1'b1; mux_done = 1'b0;
        tick(); tick();

        chk("rst_busy", busy, 0);
        chk("rst_valid", mux_valid, 0);
        chk("rst_ack", req_ack, 0);
        chk("rst_pairs", mux_pairs, 0);
        chk("rst_chan", mux_channel, 0);
        chk("rst_clamp", clamp_flag, 0);
        chk("rst_tmo", timeout_err, 0);
        chk("rst_fd", frame_done, 0);
        rst = 1'b0;
        tick();

        // single request
        enable = 1'b1;
        req_valid = 3'b001;
        tick();
        chk("single_ack", req_ack, 3'b001);
        chk("single_valid", mux_valid, 1);
        chk("single_chan", mux_channel, 0);
        chk("single_pairs", mux_pairs, 5);
        chk("single_block", mux_block == exp_blk[0], 1);
        chk("single_busy", busy, 1);
        req_valid = 3'b000;
        tick();
        chk("single_valid_pulse", mux_valid, 0);
        chk("single_ack_pulse", req_ack, 0);
        repeat (8) tick();
        chk("single_still_busy", busy, 1);
        mux_done = 1'b1;
        tick();
        mux_done = 1'b0;
        chk("single_idle", busy, 0);
        chk("single_blk_cnt", dut.blk_cnt, 1);

        rst = 1'b1;
        tick();
        rst = 1'b0;

        // round robin, clamp and frame
        req_pairs0 = 7'd3;
        req_pairs1 = 7'd100;
        req_pairs2 = 7'd64;
        exp_pairs[0] = 7'd3;
        exp_pairs[1] = 7'd64;
        exp_pairs[2] = 7'd64;
        req_valid = 3'b111;
        n_frame = 0;
        last_v = 0;
        for (int g = 0; g < 6; g++) begin
            got = 0;
            for (int w = 0; w < 10 && got == 0; w++) begin
                tick();
                if (mux_valid) got = 1;
            end
            chk("rr_grant_seen", got, 1);
            chk("rr_chan", mux_channel, g % 3);
            chk("rr_ack", req_ack, 3'b001 << (g % 3));
            chk("rr_pairs", mux_pairs, exp_pairs[g % 3]);
            chk("rr_block", mux_block == exp_blk[g % 3], 1);
            chk("rr_clamp", clamp_flag, (g >= 1) ? 1 : 0);
            if (g > 0) chk("rr_gap_ge2", (cyc - last_v) >= 2, 1);
            last_v = cyc;
            tick();
            chk("rr_busy", busy, 1);
            tick();
            mux_done = 1'b1;
            tick();
            mux_done = 1'b0;
            chk("rr_frame_done", frame_done, (g == 3) ? 1 : 0);
        end
        req_valid = 3'b000;
        tick();
        chk("frame_count", n_frame, 1);
        chk("frame_blk_cnt", dut.blk_cnt, 2);
        chk("hold_chan", mux_channel, 2);
        chk("hold_pairs", mux_pairs, 64);
        chk("clamp_sticky", clamp_flag, 1);

        // completion on the watchdog expiry edge
        req_valid = 3'b001;
        tick();
        chk("sim_valid", mux_valid, 1);
        req_valid = 3'b000;
        repeat (15) tick();
        chk("sim_busy_pre", busy, 1);
        mux_done = 1'b1;
        tick();
        mux_done = 1'b0;
        chk("sim_idle", busy, 0);
        chk("sim_no_tmo", timeout_err, 0);
        chk("sim_blk_cnt", dut.blk_cnt, 3);

        // watchdog expiry
        req_valid = 3'b001;
        tick();
        chk("wd_valid", mux_valid, 1);
        req_valid = 3'b000;
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        chk("wd_cycles", n, 16);
        chk("wd_tmo", timeout_err, 1);
        chk("wd_blk_cnt", dut.blk_cnt, 3);
        req_valid = 3'b010;
        tick();
        chk("wd_next_valid", mux_valid, 1);
        chk("wd_next_chan", mux_channel, 1);
        chk("wd_next_ack", req_ack, 3'b010);
        req_valid = 3'b000;
        tick();

        // reset while in WAIT_DONE, then a late mux_done
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rw_busy", busy, 0);
        chk("rw_tmo", timeout_err, 0);
        chk("rw_clamp", clamp_flag, 0);
        chk("rw_pairs", mux_pairs, 0);
        chk("rw_chan", mux_channel, 0);
        chk("rw_ack", req_ack, 0);
        mux_done = 1'b1;
        tick();
        mux_done = 1'b0;
        chk("late_done_cnt", dut.blk_cnt, 0);
        chk("late_done_fd", frame_done, 0);
        chk("late_done_busy", busy, 0);

        // enable gating
        enable = 1'b0;
        req_valid = 3'b010;
        n = 0;
        repeat (5) begin
            tick();
            if (mux_valid || busy || req_ack != 3'b000) n++;
        end
        chk("en_blocked", n, 0);
        enable = 1'b1;
        tick();
        chk("en_valid", mux_valid, 1);
        chk("en_chan", mux_channel, 1);
        chk("en_ack", req_ack, 3'b010);
        req_valid = 3'b000;
        mux_done = 1'b1;
        tick();
        mux_done = 1'b0;
        chk("en_done_idle", busy, 0);

        // request withdrawn before it could be granted
        enable = 1'b0;
        req_valid = 3'b100;
        tick();
        req_valid = 3'b000;
        enable = 1'b1;
        tick();
        chk("cancel_ack", req_ack, 0);
        tick();
        chk("cancel_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
